bc_branch_resolve: RTL and testbench
====================================

Name: bc_branch_resolve

Overview:
- Sits directly downstream of the B-form format decoder.
- Consumes decoded Branch Conditional (opcode 16) packets and evaluates the BO/BI condition against CR and CTR.
- Computes the branch target and owns the architectural CTR and LR registers.
- Two-stage pipeline; emits one resolved redirect packet per accepted branch to fetch and completion logic.

Parameters:
- addressWidth, 64, instruction/target address width
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID width
- funcUnitCodeSize, 3, functional unit code width
- BranchUnitID, 6, functional unit code this block accepts
- bodySize, 26, decoded body width: BO[0:4] BI[5:9] BD[10:23] AA[24] LK[25]

Ports:
- clock_i  in  1  clock, all state on rising edge
- resetn_i  in  1  asynchronous active-low reset
- enable_i  in  1  decoder packet valid
- functionalUnitType_i  in  3  packet functional unit code
- instructionOpcode_i  in  6  primary opcode
- instructionBody_i  in  26  decoded body, layout per bodySize
- instructionAddress_i  in  64  CIA
- is64Bit_i  in  1  64-bit mode
- instMajId_i  in  64  major ID
- instMinId_i  in  7  minor ID
- crValue_i  in  32  current CR, bit 0 = MSB
- ctrWrEn_i, ctrWrData_i  in  1/64  external mtctr write
- lrWrEn_i, lrWrData_i  in  1/64  external mtlr write
- stall_i  in  1  downstream stall
- flush_i  in  1  kill all in-flight branches
- stall_o  out  1  upstream stall, equals stall_i
- valid_o  out  1  resolved packet valid
- taken_o  out  1  branch taken
- nextAddress_o  out  64  taken ? target : CIA+4
- instMajId_o, instMinId_o  out  64/7  IDs of resolved branch
- ctr_o, lr_o  out  64/64  architectural CTR/LR

Behaviour:
- Reset (resetn_i low, async): all stage valids, valid_o, taken_o, nextAddress_o, IDs, ctr_o, lr_o = 0. Reset mid-flight drops in-flight branches with no CTR/LR update.
- Accept: enable_i & funcUnit==BranchUnitID & opcode==16 & !stall_i & !flush_i. Any other packet is ignored.
- Stage 1 (E1), registered on accept:
  - effCTR = stage-2 pending CTR value if stage 2 is valid and decrements, else ctr_o (back-to-back forwarding).
  - decr = !BO[2]; newCTR = decr ? effCTR-1 : effCTR (64-bit wrap; 0 -> all ones).
  - ctrZero compares low 32 bits only when !is64Bit_i, else all 64.
  - ctr_ok = BO[2] | (!ctrZero ^ BO[3]).
  - cond_ok = BO[0] | (crValue_i[BI] == BO[1]).
  - Latch taken = ctr_ok & cond_ok, newCTR, decr, LK, CIA, sign-extended (BD||00), AA, IDs, mode.
- Stage 2 (E2), one cycle after E1:
  - target = AA ? ext : CIA+ext; linkAddr = CIA+4.
  - In 32-bit mode, upper 32 bits of target and linkAddr are zeroed.
  - Drives valid_o/taken_o/nextAddress_o. valid_o is a one-cycle pulse per branch (held while stall_i).
- Latency: accept cycle N gives valid_o in cycle N+2. Throughput is 1 per cycle.
- Commit happens when valid_o & !stall_i. Then: if decr, ctr_o <= newCTR; if LK, lr_o <= linkAddr (taken or not).
- stall_i high: both stages hold, stall_o high, no commit, no accept.
- flush_i: clears E1 and E2 valids the same edge. No commit that cycle, no accept.
- External writes: ctrWrEn_i/lrWrEn_i update the register when no commit targets it that cycle. If a commit targets the same register in the same cycle, the branch commit wins and the external write is dropped.
- Forwarding also covers the E1 packet: an external CTR write in the cycle a packet enters E1 is not seen by it. Issue logic must not overlap mtctr with in-flight bc.

Test Plan:
- Reset then BO=10100 (always), BD=0x0010, AA=0, CIA=0x1000 -> valid_o at +2, taken_o=1, nextAddress_o=0x1040, ctr_o unchanged.
- ctr_o=3, three back-to-back bdnz (BO=10000, BD=-4, CIA=0x2000) -> taken 1,1,0, ctr_o 2,1,0. Third nextAddress_o=0x2004.
- CR=0x20000000, BO=01100, BI=2, LK=1, AA=1, BD=0x0100 -> taken, nextAddress_o=0x400, lr_o=CIA+4.
- is64Bit_i=0, ctr_o=0x1_00000001, bdz (BO=10010) -> low word becomes 0, taken=1. CIA=0xFFFFFFFC, BD=+8 -> nextAddress_o=0x4, upper bits 0.
- stall_i held 3 cycles with two branches in flight -> outputs hold, no CTR commit until release. Then one pulse per branch.
- flush_i with a bdnz in E2 -> no valid_o, ctr_o unchanged. Simultaneous ctrWrEn_i with a decrementing commit -> committed value wins.

Source files
------------

// File: rtl/bc_branch_resolve.sv
// bc_branch_resolve: two-stage Branch Conditional (opcode 16) resolver that owns CTR and LR.
module bc_branch_resolve #(
  parameter int addressWidth = 64,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth = 7,
  parameter int funcUnitCodeSize = 3,
  parameter int BranchUnitID = 6,
  parameter int bodySize = 26
) (
  input  logic                               clock_i,
  input  logic                               resetn_i,
  input  logic                               enable_i,
  input  logic [funcUnitCodeSize-1:0]        functionalUnitType_i,
  input  logic [5:0]                         instructionOpcode_i,
  input  logic [bodySize-1:0]                instructionBody_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [instructionCounterWidth-1:0] instMajId_i,
  input  logic [instMinIdWidth-1:0]          instMinId_i,
  input  logic [31:0]                        crValue_i,
  input  logic                               ctrWrEn_i,
  input  logic [addressWidth-1:0]            ctrWrData_i,
  input  logic                               lrWrEn_i,
  input  logic [addressWidth-1:0]            lrWrData_i,
  input  logic                               stall_i,
  input  logic                               flush_i,
  output logic                               stall_o,
  output logic                               valid_o,
  output logic                               taken_o,
  output logic [addressWidth-1:0]            nextAddress_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic [instMinIdWidth-1:0]          instMinId_o,
  output logic [addressWidth-1:0]            ctr_o,
  output logic [addressWidth-1:0]            lr_o
);
  localparam int AW = addressWidth;
  logic [0:4] bo, bi;
  logic [13:0] bd;
  logic accept, commit, decr, ctr_zero, ctr_ok, cond_ok;
  logic [AW-1:0] eff_ctr, new_ctr, ext, mask, target, link_addr;
  logic e1_valid, e1_taken, e1_decr, e1_lk, e1_aa, e1_is64;
  logic [AW-1:0] e1_new_ctr, e1_cia, e1_ext;
  logic [instructionCounterWidth-1:0] e1_maj;
  logic [instMinIdWidth-1:0] e1_min;
  logic e2_decr, e2_lk;
  logic [AW-1:0] e2_new_ctr, e2_link;
  // body fields use big-endian bit numbering: BO[0] is the body MSB
  assign bo = instructionBody_i[bodySize-1 -: 5];
  assign bi = instructionBody_i[bodySize-6 -: 5];
  assign bd = instructionBody_i[bodySize-11 -: 14];
  assign accept = enable_i && functionalUnitType_i == funcUnitCodeSize'(BranchUnitID) &&
                  instructionOpcode_i == 6'd16 && !stall_i && !flush_i;
  assign commit = valid_o && !stall_i && !flush_i;
  assign decr = !bo[2];
  // youngest in-flight decrement wins so back-to-back bdnz chains see each other
  assign eff_ctr = e1_valid && e1_decr ? e1_new_ctr : valid_o && e2_decr ? e2_new_ctr : ctr_o;
  assign new_ctr = decr ? eff_ctr - AW'(1) : eff_ctr;
  assign ctr_zero = is64Bit_i ? new_ctr == '0 : new_ctr[31:0] == 32'd0;
  assign ctr_ok = bo[2] || (!ctr_zero ^ bo[3]);
  assign cond_ok = bo[0] || crValue_i[5'd31 - bi] == bo[1];
  assign ext = {{(AW-16){bd[13]}}, bd, 2'b00};
  assign mask = e1_is64 ? '1 : AW'({32{1'b1}});
  assign target = (e1_aa ? e1_ext : e1_cia + e1_ext) & mask;
  assign link_addr = (e1_cia + AW'(4)) & mask;
  assign stall_o = stall_i;
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      e1_valid <= 1'b0;
      e1_taken <= 1'b0;
      e1_decr <= 1'b0;
      e1_lk <= 1'b0;
      e1_aa <= 1'b0;
      e1_is64 <= 1'b0;
      e1_new_ctr <= '0;
      e1_cia <= '0;
      e1_ext <= '0;
      e1_maj <= '0;
      e1_min <= '0;
      valid_o <= 1'b0;
      taken_o <= 1'b0;
      nextAddress_o <= '0;
      instMajId_o <= '0;
      instMinId_o <= '0;
      e2_decr <= 1'b0;
      e2_lk <= 1'b0;
      e2_new_ctr <= '0;
      e2_link <= '0;
      ctr_o <= '0;
      lr_o <= '0;
    end else begin
      if (flush_i) begin
        e1_valid <= 1'b0;
        valid_o <= 1'b0;
      end else if (!stall_i) begin
        e1_valid <= accept;
        if (accept) begin
          e1_taken <= ctr_ok && cond_ok;
          e1_decr <= decr;
          e1_lk <= instructionBody_i[0];
          e1_aa <= instructionBody_i[1];
          e1_is64 <= is64Bit_i;
          e1_new_ctr <= new_ctr;
          e1_cia <= instructionAddress_i;
          e1_ext <= ext;
          e1_maj <= instMajId_i;
          e1_min <= instMinId_i;
        end
        valid_o <= e1_valid;
        taken_o <= e1_valid && e1_taken;
        nextAddress_o <= e1_taken ? target : link_addr;
        instMajId_o <= e1_maj;
        instMinId_o <= e1_min;
        e2_decr <= e1_decr;
        e2_lk <= e1_lk;
        e2_new_ctr <= e1_new_ctr;
        e2_link <= link_addr;
      end
      ctr_o <= commit && e2_decr ? e2_new_ctr : ctrWrEn_i ? ctrWrData_i : ctr_o;
      lr_o <= commit && e2_lk ? e2_link : lrWrEn_i ? lrWrData_i : lr_o;
    end
  end
endmodule

// File: tb/tb_bc_branch_resolve.sv
// tb_bc_branch_resolve: directed and randomized checks of bc_branch_resolve against an architectural model.
module tb_bc_branch_resolve;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn, enable, is64, ctr_we, lr_we, stall, flush;
  logic [2:0] fu;
  logic [5:0] op;
  logic [25:0] body;
  logic [63:0] cia, maj, ctr_wd, lr_wd;
  logic [6:0] min;
  logic [31:0] cr;
  logic stall_o, valid, taken;
  logic [63:0] next, maj_o, ctr, lr;
  logic [6:0] min_o;
  int n_checks = 0;
  int n_fail = 0;

  bc_branch_resolve dut (
    .clock_i(clk), .resetn_i(resetn), .enable_i(enable), .functionalUnitType_i(fu),
    .instructionOpcode_i(op), .instructionBody_i(body), .instructionAddress_i(cia),
    .is64Bit_i(is64), .instMajId_i(maj), .instMinId_i(min), .crValue_i(cr),
    .ctrWrEn_i(ctr_we), .ctrWrData_i(ctr_wd), .lrWrEn_i(lr_we), .lrWrData_i(lr_wd),
    .stall_i(stall), .flush_i(flush), .stall_o(stall_o), .valid_o(valid), .taken_o(taken),
    .nextAddress_o(next), .instMajId_o(maj_o), .instMinId_o(min_o), .ctr_o(ctr), .lr_o(lr)
  );

  typedef struct packed {
    logic v, taken, decr, lk;
    logic [63:0] next, nctr, link, maj;
    logic [6:0] min;
  } ent_t;
  ent_t m1, m2;
  logic [63:0] m_ctr, m_lr, m_spec;

  // architectural meaning of one bc, given the CTR value it observes
  function automatic ent_t model_branch(input logic [0:4] bo, input logic [0:4] bi, input logic [0:13] bd,
                                        input logic aa, input logic lk, input logic [63:0] a, input logic m64,
                                        input logic [0:31] crb, input logic [63:0] eff, input logic [63:0] mj,
                                        input logic [6:0] mn);
    ent_t e;
    longint off;
    logic [63:0] tgt, msk;
    logic zero;
    e = '0;
    e.v = 1'b1;
    e.decr = !bo[2];
    e.nctr = e.decr ? eff - 64'd1 : eff;
    zero = m64 ? (e.nctr == 64'd0) : (e.nctr[31:0] == 32'd0);
    e.taken = (bo[2] || (!zero ^ bo[3])) && (bo[0] || crb[bi] == bo[1]);
    off = $signed({bd, 2'b00});
    msk = m64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    tgt = (aa ? 64'(off) : a + 64'(off)) & msk;
    e.link = (a + 64'd4) & msk;
    e.next = e.taken ? tgt : e.link;
    e.lk = lk;
    e.maj = mj;
    e.min = mn;
    return e;
  endfunction

  task automatic step();
    ent_t n;
    logic acc, com;
    @(posedge clk);
    if (!resetn) begin
      m1 = '0; m2 = '0; m_ctr = '0; m_lr = '0; m_spec = '0;
    end else begin
      acc = enable && fu == 3'd6 && op == 6'd16 && !stall && !flush;
      com = m2.v && !stall && !flush;
      n = '0;
      if (acc) begin
        n = model_branch(body[25:21], body[20:16], body[15:2], body[1], body[0], cia, is64, cr, m_spec, maj, min);
        if (n.decr) m_spec = n.nctr;
      end
      if (com && m2.decr) m_ctr = m2.nctr;
      else if (ctr_we) begin m_ctr = ctr_wd; m_spec = ctr_wd; end
      if (com && m2.lk) m_lr = m2.link;
      else if (lr_we) m_lr = lr_wd;
      if (flush) begin m1.v = 1'b0; m2.v = 1'b0; m_spec = m_ctr; end
      else if (!stall) begin m2 = m1; m1 = n; end
    end
    #1;
  endtask

  task automatic set_pkt(input logic [4:0] bo, input logic [4:0] bi, input logic [13:0] bd,
                         input logic aa, input logic lk, input logic [63:0] a);
    enable = 1'b1; fu = 3'd6; op = 6'd16;
    body = {bo, bi, bd, aa, lk};
    cia = a;
    maj = {$urandom, $urandom};
    min = 7'($urandom);
  endtask

  task automatic idle();
    enable = 1'b0;
  endtask

  task automatic write_ctr(input logic [63:0] v);
    ctr_we = 1'b1; ctr_wd = v;
    step();
    ctr_we = 1'b0;
  endtask

  task automatic do_reset();
    idle(); stall = 1'b0; flush = 1'b0; ctr_we = 1'b0; lr_we = 1'b0;
    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %h want 0", valid); end
    n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %h want 0", taken); end
    n_checks++; if (next !== 64'd0) begin n_fail++; $display("FAIL rst_next: got %h want 0", next); end
    n_checks++; if ({maj_o, min_o} !== 71'd0) begin n_fail++; $display("FAIL rst_ids: got %h/%h want 0", maj_o, min_o); end
    n_checks++; if ({ctr, lr} !== 128'd0) begin n_fail++; $display("FAIL rst_ctr_lr: got %h/%h want 0", ctr, lr); end
    write_ctr(64'd7);
    set_pkt(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b1, 64'h800);
    step();
    idle();
    resetn = 1'b0;
    #1;
    n_checks++; if ({ctr, valid} !== 65'd0) begin n_fail++; $display("FAIL rst_async: got ctr %h valid %h want 0", ctr, valid); end
    step();
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (valid !== 1'b0 || ctr !== 64'd0 || lr !== 64'd0) begin n_fail++; $display("FAIL rst_midflight: got valid %h ctr %h lr %h want 0", valid, ctr, lr); end
    end
  endtask

  task automatic test_always_taken();
    is64 = 1'b1;
    set_pkt(5'b10100, 5'd0, 14'h0010, 1'b0, 1'b0, 64'h1000);
    step();
    idle();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL at_early: got valid %h want 0", valid); end
    step();
    n_checks++; if (valid !== 1'b1 || taken !== 1'b1) begin n_fail++; $display("FAIL at_taken: got %h/%h want 1/1", valid, taken); end
    n_checks++; if (next !== 64'h1040) begin n_fail++; $display("FAIL at_next: got %h want 1040", next); end
    n_checks++; if (maj_o !== m2.maj || min_o !== m2.min) begin n_fail++; $display("FAIL at_ids: got %h/%h want %h/%h", maj_o, min_o, m2.maj, m2.min); end
    step();
    n_checks++; if (valid !== 1'b0 || ctr !== 64'd0) begin n_fail++; $display("FAIL at_pulse: got valid %h ctr %h want 0/0", valid, ctr); end
  endtask

  task automatic test_bdnz_back_to_back();
    logic xt [3] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] xn [3] = '{64'h1FF0, 64'h1FF0, 64'h2004};
    write_ctr(64'd3);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_pkt(5'b10000, 5'd0, 14'h3FFC, 1'b0, 1'b0, 64'h2000);
      else idle();
      step();
      if (i >= 1 && i <= 3) begin
        n_checks++; if (valid !== 1'b1 || taken !== xt[i-1]) begin n_fail++; $display("FAIL bdnz_taken%0d: got %h/%h want 1/%h", i, valid, taken, xt[i-1]); end
        n_checks++; if (next !== xn[i-1]) begin n_fail++; $display("FAIL bdnz_next%0d: got %h want %h", i, next, xn[i-1]); end
        n_checks++; if (ctr !== 64'(4 - i)) begin n_fail++; $display("FAIL bdnz_ctr%0d: got %h want %h", i, ctr, 64'(4 - i)); end
      end
    end
    n_checks++; if (valid !== 1'b0 || ctr !== 64'd0) begin n_fail++; $display("FAIL bdnz_end: got valid %h ctr %h want 0/0", valid, ctr); end
  endtask

  task automatic test_cr_link();
    cr = 32'h2000_0000;
    set_pkt(5'b01100, 5'd2, 14'h0100, 1'b1, 1'b1, 64'h3000);
    step(); idle(); step();
    n_checks++; if (valid !== 1'b1 || taken !== 1'b1 || next !== 64'h400) begin n_fail++; $display("FAIL cr_taken: got %h/%h/%h want 1/1/400", valid, taken, next); end
    step();
    n_checks++; if (lr !== 64'h3004) begin n_fail++; $display("FAIL cr_lr: got %h want 3004", lr); end
    set_pkt(5'b01100, 5'd3, 14'h0100, 1'b1, 1'b1, 64'h5000);
    step(); idle(); step();
    n_checks++; if (valid !== 1'b1 || taken !== 1'b0 || next !== 64'h5004) begin n_fail++; $display("FAIL cr_nt: got %h/%h/%h want 1/0/5004", valid, taken, next); end
    step();
    n_checks++; if (lr !== 64'h5004) begin n_fail++; $display("FAIL cr_nt_lr: got %h want 5004", lr); end
  endtask

  task automatic test_mode32();
    write_ctr(64'h1_0000_0001);
    is64 = 1'b0;
    set_pkt(5'b10010, 5'd0, 14'h0002, 1'b0, 1'b0, 64'hFFFF_FFFC);
    step(); idle(); step();
    is64 = 1'b1;
    n_checks++; if (valid !== 1'b1 || taken !== 1'b1 || next !== 64'h4) begin n_fail++; $display("FAIL m32_next: got %h/%h/%h want 1/1/4", valid, taken, next); end
    step();
    n_checks++; if (ctr !== 64'h1_0000_0000) begin n_fail++; $display("FAIL m32_ctr: got %h want 100000000", ctr); end
  endtask

  task automatic test_stall();
    write_ctr(64'd10);
    set_pkt(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b0, 64'h4000);
    step();
    set_pkt(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b0, 64'h4100);
    step();
    idle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (valid !== 1'b1 || next !== 64'h4010 || stall_o !== 1'b1 || ctr !== 64'd10) begin n_fail++; $display("FAIL stall_hold%0d: got valid %h next %h stall_o %h ctr %h want 1/4010/1/a", i, valid, next, stall_o, ctr); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (valid !== 1'b1 || next !== 64'h4110 || ctr !== 64'd9 || stall_o !== 1'b0) begin n_fail++; $display("FAIL stall_rel: got valid %h next %h ctr %h stall_o %h want 1/4110/9/0", valid, next, ctr, stall_o); end
    step();
    n_checks++; if (valid !== 1'b0 || ctr !== 64'd8) begin n_fail++; $display("FAIL stall_end: got valid %h ctr %h want 0/8", valid, ctr); end
  endtask

  task automatic test_flush_conflict();
    write_ctr(64'd5);
    set_pkt(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b0, 64'h6000);
    step(); idle(); step();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL fl_pre: got valid %h want 1", valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (valid !== 1'b0 || ctr !== 64'd5) begin n_fail++; $display("FAIL fl_drop%0d: got valid %h ctr %h want 0/5", i, valid, ctr); end
      step();
    end
    set_pkt(5'b10000, 5'd0, 14'h0004, 1'b0, 1'b0, 64'h6000);
    step(); idle(); step();
    ctr_we = 1'b1; ctr_wd = 64'h77;
    step();
    ctr_we = 1'b0;
    n_checks++; if (ctr !== 64'd4) begin n_fail++; $display("FAIL conflict_ctr: got %h want 4", ctr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      stall = $urandom_range(0, 99) < 15;
      flush = $urandom_range(0, 99) < 3;
      cr = $urandom;
      is64 = $urandom_range(0, 3) != 0;
      lr_we = $urandom_range(0, 9) == 0;
      lr_wd = {$urandom, $urandom};
      ctr_we = 1'b0;
      if ($urandom_range(0, 99) < 70) begin
        set_pkt(5'($urandom), 5'($urandom), 14'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom} & ~64'd3);
        if ($urandom_range(0, 9) == 0) fu = 3'($urandom);
        if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      end else begin
        idle();
        if (!m1.v && !m2.v && $urandom_range(0, 2) == 0) begin
          ctr_we = 1'b1;
          ctr_wd = {32'($urandom_range(0, 1)), 32'($urandom_range(0, 3))};
        end
      end
      step();
      n_checks++; if (valid !== m2.v) begin n_fail++; $display("FAIL rnd_valid%0d: got %h want %h", i, valid, m2.v); end
      if (m2.v) begin
        n_checks++; if (taken !== m2.taken || next !== m2.next) begin n_fail++; $display("FAIL rnd_res%0d: got %h/%h want %h/%h", i, taken, next, m2.taken, m2.next); end
        n_checks++; if (maj_o !== m2.maj || min_o !== m2.min) begin n_fail++; $display("FAIL rnd_ids%0d: got %h/%h want %h/%h", i, maj_o, min_o, m2.maj, m2.min); end
      end
      n_checks++; if (ctr !== m_ctr || lr !== m_lr) begin n_fail++; $display("FAIL rnd_regs%0d: got %h/%h want %h/%h", i, ctr, lr, m_ctr, m_lr); end
      n_checks++; if (stall_o !== stall) begin n_fail++; $display("FAIL rnd_stall%0d: got %h want %h", i, stall_o, stall); end
    end
    stall = 1'b0; flush = 1'b0; lr_we = 1'b0; ctr_we = 1'b0;
    idle();
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; fu = 3'd6; op = 6'd16; body = '0; cia = '0; is64 = 1'b1;
    maj = '0; min = '0; cr = '0; ctr_we = 1'b0; ctr_wd = '0; lr_we = 1'b0; lr_wd = '0;
    stall = 1'b0; flush = 1'b0;
    test_reset();
    test_always_taken();
    test_bdnz_back_to_back();
    test_cr_link();
    test_mode32();
    test_stall();
    test_flush_conflict();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
